// File: rtl/mac_operand_arbiter.sv
// Round-robin, burst-limited arbiter sharing one registered multiplier among NREQ requesters; tags each product with its requester index.
// Latency: a transfer at edge t shows up on wr_En/wr_data after edge t+1 (2-stage pipe), 1 pair/cycle sustained.
// Backpressure: wFull with a valid s2 freezes both stages and drops every req_ready to 0; nothing is lost or duplicated.
module mac_operand_arbiter #(
    parameter  int WIDTH = 4,
    parameter  int NREQ  = 4,
    parameter  int BURST = 2,
    localparam int TAGW  = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    wFull,
    output logic                    wr_En,
    output logic [TAGW+2*WIDTH-1:0] wr_data,
    output logic                    busy
);
    localparam int              CNTW       = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CNTW-1:0] BURST_LAST = CNTW'(BURST - 1);

    typedef struct packed {
        logic [TAGW-1:0]  tag;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } s1_t;

    typedef struct packed {
        logic [TAGW-1:0]    tag;
        logic [2*WIDTH-1:0] prod;
    } s2_t;

    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];

    s1_t             s1;
    s2_t             s2;
    logic            s1_valid;
    logic            s2_valid;
    logic [TAGW-1:0] rr_ptr;
    logic [TAGW-1:0] owner;
    logic [CNTW-1:0] burst_cnt;
    logic            prev_xfer;

    logic            adv;
    logic            rr_found;
    logic [TAGW-1:0] rr_idx;
    logic [TAGW-1:0] cand;
    logic            cont_ok;
    logic            gnt_vld;
    logic            gnt_cont;
    logic [TAGW-1:0] gnt_idx;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
        assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end

    assign adv = ~(s2_valid & wFull);

    // First valid requester strictly after the last grantee, wrapping modulo NREQ.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = TAGW'((int'(rr_ptr) + k) % NREQ);
            if (!rr_found && req_valid[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    // The owner keeps the grant only while its burst is unbroken and under the cap.
    assign cont_ok = prev_xfer & req_valid[owner] & (burst_cnt < BURST_LAST);

    always_comb begin
        gnt_vld  = 1'b0;
        gnt_cont = 1'b0;
        gnt_idx  = '0;
        if (adv) begin
            if (cont_ok) begin
                gnt_vld  = 1'b1;
                gnt_cont = 1'b1;
                gnt_idx  = owner;
            end else if (rr_found) begin
                gnt_vld  = 1'b1;
                gnt_idx  = rr_idx;
            end
        end
    end

    assign req_ready = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1        <= '0;
            s2        <= '0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            rr_ptr    <= TAGW'(NREQ - 1);
            owner     <= '0;
            burst_cnt <= '0;
            prev_xfer <= 1'b0;
        end else begin
            prev_xfer <= gnt_vld;
            if (adv) begin
                s1_valid <= gnt_vld;
                if (gnt_vld) begin
                    s1.tag <= gnt_idx;
                    s1.a   <= a_arr[gnt_idx];
                    s1.b   <= b_arr[gnt_idx];
                    rr_ptr <= gnt_idx;
                    if (gnt_cont) begin
                        burst_cnt <= burst_cnt + CNTW'(1);
                    end else begin
                        owner     <= gnt_idx;
                        burst_cnt <= '0;
                    end
                end
                s2_valid <= s1_valid;
                // Data only moves with a valid s1 so wr_data keeps its last product across bubbles.
                if (s1_valid) begin
                    s2.tag  <= s1.tag;
                    s2.prod <= (2*WIDTH)'(s1.a) * (2*WIDTH)'(s1.b);
                end
            end
        end
    end

    assign wr_En   = s2_valid;
    assign wr_data = s2;
    assign busy    = s1_valid | s2_valid;

endmodule

// File: doc/mac_operand_arbiter.md
Name: mac_operand_arbiter

Overview:
Shares one registered multiplier stage between NREQ operand requesters and feeds the MAC write-side FIFO. Selection is round-robin with a bounded burst per requester. Each product is tagged with its requester index before it is written into the asynchronous FIFO. FIFO-full backpressure stalls the internal 2-stage pipeline, so no data is lost.

Parameters:
WIDTH, 4, operand width in bits (D1/D2 each)
NREQ, 4, number of requesters (2..16)
BURST, 2, max consecutive grants to one requester while others wait (1..15)
TAGW, $clog2(NREQ), tag width; derived, not overridden

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  NREQ  per-requester operand-pair valid
req_a  input  NREQ*WIDTH  packed D1 operands, requester i at [i*WIDTH +: WIDTH]
req_b  input  NREQ*WIDTH  packed D2 operands, same packing
req_ready  output  NREQ  one-hot (or zero) accept, combinational
wFull  input  1  FIFO write-side full flag
wr_En  output  1  FIFO write enable, registered
wr_data  output  TAGW+2*WIDTH  {tag, product}, registered
busy  output  1  s1_valid | s2_valid

Behaviour:
- Reset (async, active-high): s1_valid=0, s2_valid=0, wr_En=0, wr_data=0, rr_ptr=NREQ-1, burst_cnt=0, owner=0. Requester 0 has first priority after reset. In-flight pairs are dropped; this is not an error.
- adv = ~(s2_valid & wFull). The pipeline moves only when adv=1. When adv=0, s1 and s2 hold and all req_ready are 0.
- Grant (combinational, valid only when adv=1):
  - If req_valid[owner] and burst_cnt<BURST-1 and the previous cycle transferred from owner → grant owner.
  - Otherwise grant the first valid i searching rr_ptr+1, rr_ptr+2, … modulo NREQ.
  - If no request is valid, there is no grant.
- req_ready[g]=adv for the granted g. All other bits are 0. req_ready never depends on wFull except through adv.
- Transfer = req_valid[g] & req_ready[g]. On transfer:
  - s1 <= {g, a[g], b[g]}, s1_valid <= 1.
  - If g==owner and the burst is continuing: burst_cnt++. Otherwise owner<=g, burst_cnt<=0.
  - rr_ptr<=g.
- On adv with no transfer: s1_valid<=0. A break in a burst resets burst_cnt to 0 the next time a grant is made.
- Stage 2 on adv: s2 <= {s1.tag, s1.a*s1.b (unsigned, full 2*WIDTH, no truncation)}, s2_valid<=s1_valid.
- wr_En=s2_valid and wr_data=s2 contents. A FIFO write occurs in any cycle with wr_En=1 and wFull=0.
  - While stalled, wr_En and wr_data hold stable until the write is taken.
  - When s2_valid=0, wr_data holds its last value; only wr_En is meaningful.
- Latency: transfer at edge t → wr_En=1 with that product after edge t+1, provided no stall. Throughput is 1 pair per cycle when wFull=0.
- Stalls do not compress bubbles. A stalled s2 with an empty s1 keeps s1 empty.
- Ordering: products leave in grant order. A requester's pairs are never reordered.
- wFull asserting and deasserting on the same edge as a transfer: adv is evaluated from the current-cycle s2_valid and wFull only.

Test Plan:
- Single requester: reset, then req_valid=0001 with a0=3, b0=5, one cycle. Expect req_ready=0001 that cycle, then wr_En=1 with wr_data={2'd0,8'd15} two edges later, then wr_En=0.
- All four requesters continuously valid, BURST=2, wFull=0. Expect grant order 0,0,1,1,2,2,3,3,0,…, and tags on wr_data in the same order with no gaps.
- Max operands: a=15, b=15 on requester 3. Expect wr_data={2'd3,8'd225}.
- Backpressure: stream from requester 1, then wFull=1 for 5 cycles while wr_En=1. Expect wr_En/wr_data stable, req_ready=0 throughout, and no lost or duplicated products after wFull drops (count 10 in, 10 out).
- Sparse requesters: only 0 and 2 valid, BURST=1. Expect strict alternation 0,2,0,2; index 1 and 3 are skipped with no idle cycle.
- Reset mid-operation: assert reset asynchronously while s1 and s2 are both valid. Expect wr_En=0 and busy=0 immediately (before the next clk edge). After release, the first grant goes to requester 0.
